// File: rtl/ysyx_25020042_pkg.sv
// Shared constants for the ysyx_25020042 register file and scoreboard.
// Writeback port identifiers and the value that storage takes on reset.
package ysyx_25020042_pkg;
  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam logic RST_DATA_BIT = 1'b0;
endpackage

// File: rtl/ysyx_25020042_gpr_entry.sv
// One architectural register: data word plus its pending-write busy bit.
// busy_nxt is exported so the top level can keep a registered popcount in step.
module ysyx_25020042_gpr_entry
  import ysyx_25020042_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_set,
  input  logic             flush,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             busy_nxt
);

  // Priority low to high: writeback clear, issue set, flush clear.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)   busy_nxt = 1'b0;
    if (iss_set) busy_nxt = 1'b1;
    if (flush)   busy_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= {WIDTH{RST_DATA_BIT}};
      busy <= 1'b0;
    end else begin
      if (wr_en) data <= wr_data;
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/ysyx_25020042_gpr_sb.sv
// General-purpose register file with per-register busy scoreboard.
// Two writeback ports (LSU wins on collision), NR_READ read ports, optional forwarding.
module ysyx_25020042_gpr_sb
  import ysyx_25020042_pkg::*;
#(
  parameter int REG_ADDR_LEN = 5,
  parameter int WIDTH        = 32,
  parameter int NR_READ      = 2,
  parameter int BYPASS       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NR_READ*REG_ADDR_LEN-1:0] rd_addr,
  output logic [NR_READ*WIDTH-1:0]        rd_data,
  output logic [NR_READ-1:0]              rd_busy,
  input  logic [1:0]                      wr_en,
  input  logic [2*REG_ADDR_LEN-1:0]       wr_addr,
  input  logic [2*WIDTH-1:0]              wr_data,
  input  logic                            iss_en,
  input  logic [REG_ADDR_LEN-1:0]         iss_rd,
  input  logic                            flush,
  output logic [REG_ADDR_LEN:0]           inflight
);

  localparam int NR_REGS = 2**REG_ADDR_LEN;

  logic [REG_ADDR_LEN-1:0] wa_alu, wa_lsu;
  logic [WIDTH-1:0]        wd_alu, wd_lsu;
  logic [WIDTH-1:0]        regs [NR_REGS];
  logic [NR_REGS-1:0]      busy, busy_nxt, hit_alu, hit_lsu;
  logic [REG_ADDR_LEN:0]   cnt_nxt;

  assign wa_alu = wr_addr[WB_ALU*REG_ADDR_LEN +: REG_ADDR_LEN];
  assign wa_lsu = wr_addr[WB_LSU*REG_ADDR_LEN +: REG_ADDR_LEN];
  assign wd_alu = wr_data[WB_ALU*WIDTH +: WIDTH];
  assign wd_lsu = wr_data[WB_LSU*WIDTH +: WIDTH];

  for (genvar i = 0; i < NR_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      // x0 has no storage; hit bits stay low so nothing forwards from it.
      assign regs[i]     = {WIDTH{RST_DATA_BIT}};
      assign busy[i]     = 1'b0;
      assign busy_nxt[i] = 1'b0;
      assign hit_alu[i]  = 1'b0;
      assign hit_lsu[i]  = 1'b0;
    end else begin : g_entry
      assign hit_alu[i] = wr_en[WB_ALU] && (wa_alu == REG_ADDR_LEN'(i));
      assign hit_lsu[i] = wr_en[WB_LSU] && (wa_lsu == REG_ADDR_LEN'(i));

      ysyx_25020042_gpr_entry #(.WIDTH(WIDTH)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (hit_alu[i] | hit_lsu[i]),
        .wr_data  (hit_lsu[i] ? wd_lsu : wd_alu),
        .iss_set  (iss_en && (iss_rd == REG_ADDR_LEN'(i))),
        .flush    (flush),
        .data     (regs[i]),
        .busy     (busy[i]),
        .busy_nxt (busy_nxt[i])
      );
    end
  end

  // Forwarding is masked while in reset so reads stay zero regardless of writes.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NR_READ; k++) begin
      logic [REG_ADDR_LEN-1:0] a;
      a = rd_addr[k*REG_ADDR_LEN +: REG_ADDR_LEN];
      rd_data[k*WIDTH +: WIDTH] = regs[a];
      rd_busy[k]                = busy[a];
      if (BYPASS != 0 && rst) begin
        if (hit_lsu[a])      rd_data[k*WIDTH +: WIDTH] = wd_lsu;
        else if (hit_alu[a]) rd_data[k*WIDTH +: WIDTH] = wd_alu;
        if (hit_lsu[a] || hit_alu[a]) rd_busy[k] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NR_REGS; i++) cnt_nxt = cnt_nxt + (REG_ADDR_LEN+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight <= '0;
    else      inflight <= cnt_nxt;
  end

endmodule

// File: tb/tb_ysyx_25020042_gpr_sb.sv
// Directed scoreboard bench for ysyx_25020042_gpr_sb, forwarding and non-forwarding builds.
// Expected values are queued as stimulus is driven and popped as outputs are sampled.
module tb_ysyx_25020042_gpr_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        flush;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [5:0]  inflight, inflight_nb;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  ysyx_25020042_gpr_sb #(.REG_ADDR_LEN(5), .WIDTH(32), .NR_READ(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_rd(iss_rd), .flush(flush), .inflight(inflight)
  );

  ysyx_25020042_gpr_sb #(.REG_ADDR_LEN(5), .WIDTH(32), .NR_READ(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_rd(iss_rd), .flush(flush), .inflight(inflight_nb)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_asserts++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_rd = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    push("rst_rd_data", 32'h0);  check(rd_data[31:0]);
    push("rst_rd_busy", 32'h0);  check(32'(rd_busy));
    push("rst_inflight", 32'h0); check(32'(inflight));

    // x5 write on ALU port
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
    push("x5_data", 32'hDEADBEEF); push("x5_busy", 32'h0);
    tick(); idle(); rd_addr[4:0] = 5'd5; #1;
    check(rd_data[31:0]); check(32'(rd_busy[0]));

    // x0 write and issue are ignored
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'h1234;
    iss_en = 1'b1; iss_rd = 5'd0; rd_addr[4:0] = 5'd0;
    push("x0_fwd", 32'h0); #1; check(rd_data[31:0]);
    push("x0_data", 32'h0); push("x0_busy", 32'h0); push("x0_inflight", 32'h0);
    tick(); idle(); #1;
    check(rd_data[31:0]); check(32'(rd_busy[0])); check(32'(inflight));

    // x7 written by both ports: LSU wins
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr[9:5] = 5'd7;
    push("x7_fwd", 32'h22); #1; check(rd_data[63:32]);
    push("x7_data", 32'h22); push("x7_data_nb", 32'h22);
    tick(); idle(); #1;
    check(rd_data[63:32]); check(rd_data_nb[63:32]);

    // x3 forwarding vs one-cycle latency
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'hA5A5A5A5; rd_addr[4:0] = 5'd3;
    push("x3_fwd", 32'hA5A5A5A5); push("x3_old_nb", 32'h0); #1;
    check(rd_data[31:0]); check(rd_data_nb[31:0]);
    push("x3_new_nb", 32'hA5A5A5A5);
    tick(); idle(); #1;
    check(rd_data_nb[31:0]);

    // issue x9, x10, x11
    @(negedge clk); iss_en = 1'b1; iss_rd = 5'd9;
    push("iss_x9_inflight", 32'd1); tick(); check(32'(inflight));
    @(negedge clk); iss_rd = 5'd10;
    push("iss_x10_inflight", 32'd2); tick(); check(32'(inflight));
    @(negedge clk); iss_rd = 5'd11;
    push("iss_x11_inflight", 32'd3); tick(); check(32'(inflight));

    // writeback and issue x10 together: issue wins, data still stored
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd10; wr_data[31:0] = 32'h55; iss_rd = 5'd10;
    push("x10_reiss_inflight", 32'd3); push("x10_busy", 32'h1); push("x10_data", 32'h55);
    tick(); idle(); rd_addr[4:0] = 5'd10; #1;
    check(32'(inflight)); check(32'(rd_busy[0])); check(rd_data[31:0]);

    // LSU writeback of x9 masks busy when forwarding
    @(negedge clk);
    wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'h99; rd_addr[9:5] = 5'd9;
    push("x9_busy_fwd", 32'h0); push("x9_data_fwd", 32'h99); push("x9_busy_nb", 32'h1); #1;
    check(32'(rd_busy[1])); check(rd_data[63:32]); check(32'(rd_busy_nb[1]));
    push("x9_wb_inflight", 32'd2);
    tick(); idle(); check(32'(inflight));

    // flush beats a same-cycle issue
    @(negedge clk); flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd12; rd_addr[4:0] = 5'd12;
    push("flush_inflight", 32'd0); push("flush_x12_busy", 32'h0); push("flush_inflight_nb", 32'd0);
    tick(); idle(); #1;
    check(32'(inflight)); check(32'(rd_busy[0])); check(32'(inflight_nb));

    // x4 busy and nonzero, then asynchronous reset mid-cycle
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd4; wr_data[31:0] = 32'h44; iss_en = 1'b1; iss_rd = 5'd4;
    push("x4_data", 32'h44); push("x4_busy", 32'h1); push("x4_inflight", 32'd1);
    tick(); idle(); rd_addr[4:0] = 5'd4; #1;
    check(rd_data[31:0]); check(32'(rd_busy[0])); check(32'(inflight));
    #1 rst = 1'b0;
    push("arst_x4_data", 32'h0); push("arst_x4_busy", 32'h0); push("arst_inflight", 32'd0);
    #1;
    check(rd_data[31:0]); check(32'(rd_busy[0])); check(32'(inflight));

    // first edge after reset release applies write and issue
    @(negedge clk);
    rst = 1'b1;
    wr_en = 2'b10; wr_addr[9:5] = 5'd6; wr_data[63:32] = 32'h66; iss_en = 1'b1; iss_rd = 5'd8;
    push("post_rst_x6", 32'h66); push("post_rst_x8_busy", 32'h1); push("post_rst_inflight", 32'd1);
    tick(); idle(); rd_addr = {5'd8, 5'd6}; #1;
    check(rd_data[31:0]); check(32'(rd_busy[1])); check(32'(inflight));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25020042_gpr_sb.md
YSYX_25020042_GPR_SB -- requirements
Module: ysyx_25020042_gpr_sb

Interface
REQ-001 SHALL have parameter REG_ADDR_LEN, default 5, meaning register index width; register count is 2**REG_ADDR_LEN.
REQ-002 SHALL have parameter WIDTH, default 32, meaning data width.
REQ-003 SHALL have parameter NR_READ, default 2, meaning read port count (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = write-to-read forwarding in the same cycle, 0 = none.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port rd_addr, input, NR_READ*REG_ADDR_LEN bits: read indices, port k in slice k.
REQ-008 SHALL have port rd_data, output, NR_READ*WIDTH bits: read data, combinational.
REQ-009 SHALL have port rd_busy, output, NR_READ bits: the addressed register has a pending write.
REQ-010 SHALL have port wr_en, input, 2 bits: writeback valid, port 0 = ALU, port 1 = LSU.
REQ-011 SHALL have port wr_addr, input, 2*REG_ADDR_LEN bits: writeback indices.
REQ-012 SHALL have port wr_data, input, 2*WIDTH bits: writeback data.
REQ-013 SHALL have port iss_en, input, 1 bit: an instruction with a destination issues this cycle.
REQ-014 SHALL have port iss_rd, input, REG_ADDR_LEN bits: destination index of the issuing instruction.
REQ-015 SHALL have port flush, input, 1 bit: clear all busy bits (pipeline flush).
REQ-016 SHALL have port inflight, output, REG_ADDR_LEN+1 bits: count of set busy bits.

Function
REQ-017 SHALL hold 2**REG_ADDR_LEN registers of WIDTH bits, each with a busy bit; writes update on the rising clk edge.
REQ-018 SHALL treat index 0 as hardwired: it reads 0, is never busy, and writes and issues to it are ignored.
REQ-019 SHALL, when both write ports target the same nonzero index in one cycle, store port 1 data.
REQ-020 SHALL, with BYPASS=1, return on a read the data of a same-cycle enabled write to that index (port 1 over port 0), else the stored value; with BYPASS=0 it SHALL always return the stored value (one-cycle write-to-read latency).
REQ-021 SHALL set busy[iss_rd] at the edge when iss_en=1.
REQ-022 SHALL clear busy[i] at the edge when either write port writes index i.
REQ-023 SHALL, when an issue and a writeback target the same index in one cycle, leave busy set (issue wins) and still store the write data.
REQ-024 SHALL, on flush=1, clear all busy bits at the edge with priority over a same-cycle issue; same-cycle writes still update data.
REQ-025 SHALL drive rd_busy[k] from the stored busy bit; with BYPASS=1 it SHALL be 0 when a same-cycle write targets that index.
REQ-026 SHALL keep inflight equal to the popcount of the busy bits, registered and consistent with them every cycle; maximum value 2**REG_ADDR_LEN-1.
REQ-027 SHALL perform no arithmetic on data; all data paths are WIDTH bits, with no truncation or extension.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all registers, all busy bits and inflight to 0, including mid-operation.
REQ-029 SHALL apply the first write or issue at the first rising edge after rst returns to 1.
REQ-030 SHALL drive rd_data to 0 and rd_busy to 0 during reset, since the storage is cleared.

Structure
REQ-031 SHALL place the writeback port identifiers (ALU=0, LSU=1) and the reset data value in the shared package ysyx_25020042_pkg.
REQ-032 SHALL implement the per-index storage (data and busy) as one sub-module, ysyx_25020042_gpr_entry, instantiated by generate; read muxes, forwarding and popcount stay in the top level.

Verification
REQ-033 SHALL verify: reset, then write x5=0xDEADBEEF on port 0 -> next cycle, reading x5 gives 0xDEADBEEF and rd_busy=0.
REQ-034 SHALL verify: write x0=0x1234 and issue x0 -> x0 reads 0, not busy, inflight=0.
REQ-035 SHALL verify: a same-cycle write of x7 on port 0 (0x11) and port 1 (0x22) -> x7 reads 0x22.
REQ-036 SHALL verify: with BYPASS=1, write x3=0xA5A5A5A5 while reading x3 -> rd_data=0xA5A5A5A5 in the same cycle; with BYPASS=0 -> the old value, then the new one next cycle.
REQ-037 SHALL verify: issue x9, x10, x11 in consecutive cycles -> inflight 1, 2, 3; then writeback x10 and issue x10 in the same cycle -> x10 stays busy, inflight=3; then flush -> inflight=0.
REQ-038 SHALL verify: rst asserted asynchronously mid-cycle with x4 busy and nonzero -> outputs clear immediately, x4 reads 0, inflight=0.
